// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button debouncer: 2-flop synchroniser, per-channel
// 4-state FSM with a tick counter, and a registered level, rise/fall pulses
// and a per-channel press-toggle. All logic is on the rising edge of CLK.
module multi_button_debouncer #(
  parameter int                     CHANNELS     = 5,
  parameter int                     STABLE_TICKS = 8,
  parameter int                     COUNT_WIDTH  = 5,
  parameter logic [CHANNELS-1:0]    TOGGLE_MASK  = {CHANNELS{1'b1}}
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                DIV_CLK,
  input  logic [CHANNELS-1:0] IN,
  output logic [CHANNELS-1:0] OUT,
  output logic [CHANNELS-1:0] LEVEL,
  output logic [CHANNELS-1:0] RISE,
  output logic [CHANNELS-1:0] FALL
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    COUNT_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    COUNT_LOW   = 2'd3
  } state_t;

  // Count value on which the final tick accepts the new level.
  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(STABLE_TICKS - 1);

  state_t                 state_q [CHANNELS];
  state_t                 state_d [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d   [CHANNELS];

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q,  rise_d;
  logic [CHANNELS-1:0] fall_q,  fall_d;
  logic [CHANNELS-1:0] tog_q,   tog_d;

  // Next-state logic: qualify a level change over STABLE_TICKS ticks, any revert aborts.
  always_comb begin
    level_d = level_q;
    tog_d   = tog_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE_LOW: begin
          cnt_d[i] = '0;
          if (sync2_q[i]) state_d[i] = COUNT_HIGH;
        end
        COUNT_HIGH: begin
          if (!sync2_q[i]) begin
            // Revert wins even when it coincides with a tick.
            state_d[i] = STABLE_LOW;
            cnt_d[i]   = '0;
          end else if (DIV_CLK) begin
            if (cnt_q[i] == LAST_CNT) begin
              state_d[i] = STABLE_HIGH;
              cnt_d[i]   = '0;
              level_d[i] = 1'b1;
              rise_d[i]  = 1'b1;
              tog_d[i]   = ~tog_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
          end
        end
        STABLE_HIGH: begin
          cnt_d[i] = '0;
          if (!sync2_q[i]) state_d[i] = COUNT_LOW;
        end
        COUNT_LOW: begin
          if (sync2_q[i]) begin
            state_d[i] = STABLE_HIGH;
            cnt_d[i]   = '0;
          end else if (DIV_CLK) begin
            if (cnt_q[i] == LAST_CNT) begin
              state_d[i] = STABLE_LOW;
              cnt_d[i]   = '0;
              level_d[i] = 1'b0;
              fall_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d[i] = STABLE_LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // State, synchroniser and output registers; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      tog_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= STABLE_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= IN;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      tog_q   <= tog_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign LEVEL = level_q;
  assign RISE  = rise_q;
  assign FALL  = fall_q;
  // Static mode select per channel: toggle bit or debounced level.
  assign OUT   = (tog_q & TOGGLE_MASK) | (level_q & ~TOGGLE_MASK);

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: directed scenarios plus random bouncing,
// compared every cycle against a behavioural model of the acceptance rule.
module tb_multi_button_debouncer;

  localparam int         CH   = 2;
  localparam int         ST   = 4;
  localparam logic [1:0] MASK = 2'b01;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          DIV_CLK = 1'b0;
  logic [CH-1:0] IN = '0;
  logic [CH-1:0] OUT, LEVEL, RISE, FALL;

  multi_button_debouncer #(
    .CHANNELS(CH), .STABLE_TICKS(ST), .COUNT_WIDTH(3), .TOGGLE_MASK(MASK)
  ) dut (
    .CLK(CLK), .RESET(RESET), .DIV_CLK(DIV_CLK), .IN(IN),
    .OUT(OUT), .LEVEL(LEVEL), .RISE(RISE), .FALL(FALL)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int div_mode = 0;   // 0: every 4th cycle, 1: random, 2: held high, 3: never

  // Reference model: input pipe, accepted level, and how many ticks have
  // elapsed since the sampled input started differing from the accepted level.
  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_tog = '0, m_rise = '0, m_fall = '0;
  bit            m_seen [CH];
  int            m_ticks [CH];
  int            m_rise_cnt = 0, d_rise_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    if (RESET) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_tog = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < CH; i++) begin m_seen[i] = 0; m_ticks[i] = 0; end
    end else begin
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < CH; i++) begin
        if (m_s2[i] == m_lvl[i]) begin
          m_seen[i] = 0; m_ticks[i] = 0;
        end else if (!m_seen[i]) begin
          // First cycle of a difference: ticks are counted only from the next cycle.
          m_seen[i] = 1; m_ticks[i] = 0;
        end else if (DIV_CLK) begin
          m_ticks[i]++;
          if (m_ticks[i] == ST) begin
            m_lvl[i] = m_s2[i];
            if (m_s2[i]) begin
              m_rise[i] = 1'b1; m_tog[i] = ~m_tog[i]; m_rise_cnt++;
            end else begin
              m_fall[i] = 1'b1;
            end
            m_seen[i] = 0; m_ticks[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = IN;
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after.
  task automatic step(input logic [CH-1:0] in_v, input logic rst_v);
    logic [CH-1:0] exp_out;
    IN    = in_v;
    RESET = rst_v;
    case (div_mode)
      0:       DIV_CLK = (cyc % 4 == 3);
      1:       DIV_CLK = ($urandom_range(0, 2) == 0);
      2:       DIV_CLK = 1'b1;
      default: DIV_CLK = 1'b0;
    endcase
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
    exp_out = (m_tog & MASK) | (m_lvl & ~MASK);
    if (RISE[0]) d_rise_cnt++;
    if (RISE[1]) d_rise_cnt++;
    check("level", 32'(LEVEL), 32'(m_lvl));
    check("rise",  32'(RISE),  32'(m_rise));
    check("fall",  32'(FALL),  32'(m_fall));
    check("out",   32'(OUT),   32'(exp_out));
  endtask

  task automatic run(input logic [CH-1:0] in_v, input int n, input logic rst_v);
    for (int k = 0; k < n; k++) step(in_v, rst_v);
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin m_seen[i] = 0; m_ticks[i] = 0; end

    // Reset: everything low.
    run(2'b11, 3, 1'b1);
    check("reset_outputs", 32'({OUT, LEVEL, RISE, FALL}), 32'h0);

    // Clean press and release on ch1 (level mode).
    run(2'b00, 8, 1'b0);
    run(2'b10, 30, 1'b0);
    check("press_level1", 32'(LEVEL[1]), 32'h1);
    run(2'b00, 30, 1'b0);
    check("release_level1", 32'(LEVEL[1]), 32'h0);

    // Bounce on ch0: high ~3 ticks, one-cycle dip, then held.
    run(2'b01, 12, 1'b0);
    run(2'b00, 1, 1'b0);
    run(2'b01, 30, 1'b0);
    check("bounce_out0", 32'(OUT[0]), 32'h1);
    run(2'b00, 30, 1'b0);

    // Second clean press on ch0 toggles OUT back to 0.
    run(2'b01, 30, 1'b0);
    run(2'b00, 30, 1'b0);
    check("toggle_out0", 32'(OUT[0]), 32'h0);

    // Both pressed together, then a bounce on ch1 only.
    run(2'b11, 30, 1'b0);
    run(2'b00, 30, 1'b0);
    run(2'b11, 6, 1'b0);
    run(2'b01, 1, 1'b0);
    run(2'b11, 30, 1'b0);
    run(2'b00, 30, 1'b0);

    // Reset mid-count, button held through reset release.
    run(2'b11, 12, 1'b0);
    run(2'b11, 2, 1'b1);
    check("reset_mid_count", 32'({OUT, LEVEL, RISE, FALL}), 32'h0);
    run(2'b11, 30, 1'b0);
    run(2'b00, 30, 1'b0);

    // Reverts at every phase relative to the tick: high for k cycles, then low.
    for (int k = 9; k <= 20; k++) begin
      run(2'b11, k, 1'b0);
      run(2'b00, 24, 1'b0);
    end

    // Tick held high and tick never asserted.
    div_mode = 2;
    run(2'b01, 10, 1'b0);
    run(2'b00, 10, 1'b0);
    div_mode = 3;
    run(2'b10, 20, 1'b0);
    check("no_tick_level1", 32'(LEVEL[1]), 32'h0);
    run(2'b00, 5, 1'b0);

    // Random bouncing under each tick mode with occasional resets.
    for (int blk = 0; blk < 40; blk++) begin
      div_mode = (blk % 5 == 4) ? 2 : (blk % 2);
      for (int k = 0; k < 50; k++) begin
        logic [CH-1:0] v;
        v = IN;
        if ($urandom_range(0, 9) == 0) v[0] = ~v[0];
        if ($urandom_range(0, 9) == 0) v[1] = ~v[1];
        step(v, ($urandom_range(0, 299) == 0));
      end
    end

    check("rise_total", 32'(d_rise_cnt), 32'(m_rise_cnt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_button_debouncer.md
# multi_button_debouncer

Parametrised, multi-channel push-button debouncer for the Nexys 4 DDR button bank. Each channel synchronises its raw asynchronous input into the `CLK` domain, requires the input to hold a new level for `STABLE_TICKS` consecutive enable ticks before accepting it, and emits a debounced level, single-cycle edge pulses, and an optional press-toggle output. It sits between the board pins and the timer control logic. The shared tick comes from the existing clock-divider enable.

## Interface
- `CHANNELS`, default 5: number of independent button channels.
- `STABLE_TICKS`, default 8: consecutive `DIV_CLK` ticks required to accept a level change (≥1).
- `COUNT_WIDTH`, default 5: per-channel tick counter width; must satisfy 2^`COUNT_WIDTH` ≥ `STABLE_TICKS`.
- `TOGGLE_MASK`, default {`CHANNELS`{1'b1}}: bit i = 1 selects toggle mode for channel i; bit i = 0 selects level mode.

- `CLK` input 1: system clock. One clock; all logic is on its rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `DIV_CLK` input 1: one-`CLK`-cycle enable tick, shared by all channels.
- `IN` input `CHANNELS`: raw asynchronous button inputs.
- `OUT` output `CHANNELS`: mode-selected output. Toggle state if `TOGGLE_MASK`[i] = 1, otherwise the debounced level.
- `LEVEL` output `CHANNELS`: debounced level.
- `RISE` output `CHANNELS`: one-cycle pulse when `LEVEL`[i] goes 0→1.
- `FALL` output `CHANNELS`: one-cycle pulse when `LEVEL`[i] goes 1→0.

## Operation
- **Synchroniser:** two flops per channel, `IN`[i] → s1 → s2. Only s2 (called "raw" below) feeds the FSM.
- **Per-channel FSM (2-bit):**
  - STABLE_LOW: stays while raw = 0. On raw = 1, go to COUNT_HIGH; the counter starts from 0.
  - COUNT_HIGH: on a cycle with raw = 1 and `DIV_CLK` = 1:
    - If count = `STABLE_TICKS`−1: go to STABLE_HIGH and clear the counter.
    - Otherwise: count+1.
    - If raw = 0 on any cycle: return to STABLE_LOW and clear the counter (bounce rejected).
  - STABLE_HIGH and COUNT_LOW: mirror images of the two states above.
- **Counter:** cleared in both stable states. It changes only on `DIV_CLK` cycles in the COUNT states, so it never wraps. Every channel has its own counter, and channels are fully independent.
- **Outputs:**
  - `LEVEL`[i] = 1 in STABLE_HIGH and COUNT_LOW, registered.
  - `RISE`/`FALL` are registered and asserted in the same cycle `LEVEL` changes, for exactly one cycle.
- **Toggle:**
  - Toggle mode: an internal toggle bit inverts on each accepted rise only; release does nothing.
  - Level mode: `OUT` = `LEVEL`.
- **Mode is static:** `TOGGLE_MASK` is a parameter, so the mode cannot change at run time.

## Timing
- **Reset values:** all outputs are 0 one cycle after `RESET` is sampled high. Synchroniser flops, toggle bits and counters are 0, and every FSM is in STABLE_LOW.
- **Reset mid-count:** any pending count is abandoned and no pulse is produced.
- **Reset priority:** `RESET` has priority over all other inputs on the same edge.
- **Input latency:** 2 cycles from `IN` to raw.
- **Acceptance:** occurs on the `CLK` edge of the `STABLE_TICKS`-th `DIV_CLK` tick that follows raw differing. `LEVEL`, `RISE`/`FALL` and toggle update on that edge.
- **`STABLE_TICKS` = 1:** acceptance happens on the first tick after raw differs.
- **Simultaneous tick and revert:** if raw reverts in the same cycle as a `DIV_CLK` tick, the revert wins and the count clears.
- **Button held through reset:** after release from reset, raw = 1 against `LEVEL` = 0. The channel counts normally, then produces `RISE` and a toggle.
- **`DIV_CLK` held high:** acceptance occurs `STABLE_TICKS` cycles after raw changes; this is legal.
- **`DIV_CLK` never asserted:** channels stay in their COUNT states indefinitely with no output change.
- **Throughput:** one accepted edge per channel at most every `STABLE_TICKS` ticks. Multiple channels may pulse in the same cycle.

## Test plan
Bench configuration for all scenarios: `CHANNELS`=2, `STABLE_TICKS`=4, `TOGGLE_MASK`=2'b01, `DIV_CLK` every 4th cycle.

1. **Clean press:** `IN`[1] 0→1 and held → `LEVEL`[1]=1 and `RISE`[1] high for exactly 1 cycle, on the 4th tick after raw rose; `OUT`[1] follows `LEVEL`[1]. Release → `FALL`[1] pulse after 4 ticks.
2. **Bounce:** `IN`[0] high for 3 ticks, low for 1 cycle, then high → no `RISE` until 4 full ticks after the last rise; `OUT`[0] toggles 0→1 exactly once.
3. **Toggle:** two clean press/release cycles on ch0 → `OUT`[0] goes 0→1→0, changing only on the `RISE`[0] cycles, while `LEVEL`[0] pulses twice.
4. **Independence:** ch0 and ch1 pressed on the same cycle → `RISE`=2'b11 in the same cycle. Bounce on ch1 only → ch0 timing is unchanged.
5. **Reset mid-count:** assert `RESET` after 2 ticks of a press → all outputs 0 with no pulse. Hold `IN` through reset release → `RISE` occurs 4 ticks plus 2 cycles after reset drops.
6. **Revert on tick edge:** raw returns low exactly on a `DIV_CLK` cycle at count=3 → no acceptance, the counter reads 0, and the FSM is in STABLE_LOW.
